poly_ctrl: RTL

POLY_CTRL -- requirements
Module: poly_ctrl

---
 rtl/poly_pkg.sv | 50 +++++
 rtl/wb_delay.sv | 41 ++++
 rtl/poly_ctrl.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/poly_pkg.sv
// poly_pkg: shared definitions for the polynomial-arithmetic controller.
//   - mode codes sampled with start
//   - butterfly-datapath opcodes driven on sel
//   - coefficient block size and NTT pass count
//   - controller state encoding and small decode helpers
package poly_pkg;

  localparam int N_WORDS  = 32;
  localparam int N_PASSES = 8;
  localparam int ADDR_W   = 5;

  // Operation mode codes
  localparam logic [1:0] MODE_NTT  = 2'b00;
  localparam logic [1:0] MODE_INTT = 2'b01;
  localparam logic [1:0] MODE_MULT = 2'b10;
  localparam logic [1:0] MODE_ADD  = 2'b11;

  // Butterfly-datapath opcodes
  localparam logic [2:0] SEL_IDLE = 3'b000;
  localparam logic [2:0] SEL_NTT  = 3'b001;
  localparam logic [2:0] SEL_INTT = 3'b100;
  localparam logic [2:0] SEL_MULT = 3'b010;
  localparam logic [2:0] SEL_ADD  = 3'b110;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_READ  = 2'b01,
    ST_DRAIN = 2'b10,
    ST_FIN   = 2'b11
  } state_e;

  function automatic logic [2:0] sel_of_mode(input logic [1:0] m);
    case (m)
      MODE_NTT:  return SEL_NTT;
      MODE_INTT: return SEL_INTT;
      MODE_MULT: return SEL_MULT;
      default:   return SEL_ADD;
    endcase
  endfunction

  // Butterfly layer geometry: the last two NTT/INTT passes use the
  // narrow-span layouts, element-wise modes always use layout 2.
  function automatic logic [1:0] layer_of(input logic [1:0] m, input logic [2:0] p);
    if (m == MODE_MULT || m == MODE_ADD) return 2'd2;
    if (p == 3'd7) return 2'd2;
    if (p == 3'd6) return 2'd1;
    return 2'd0;
  endfunction

endpackage

// File: rtl/wb_delay.sv
// wb_delay: valid-tagged shift line carrying a write-back address.
//   Parameters: WIDTH (data bits), DEPTH (cycles of delay, >= 1).
//   Ports:
//     clk, rst      clock, asynchronous active-low reset (clears every stage)
//     in_valid      tag of the entering word
//     in_data       entering word; stored as zero when in_valid is low
//     out_valid     tag delayed exactly DEPTH cycles
//     out_data      word delayed exactly DEPTH cycles
module wb_delay #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  logic [DEPTH-1:0] vld_q;
  logic [WIDTH-1:0] dat_q [DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q <= '0;
      for (int i = 0; i < DEPTH; i++) dat_q[i] <= '0;
    end else begin
      vld_q[0] <= in_valid;
      dat_q[0] <= in_valid ? in_data : '0;
      for (int i = 1; i < DEPTH; i++) begin
        vld_q[i] <= vld_q[i-1];
        dat_q[i] <= dat_q[i-1];
      end
    end
  end

  assign out_valid = vld_q[DEPTH-1];
  assign out_data  = dat_q[DEPTH-1];

endmodule

// File: rtl/poly_ctrl.sv
// poly_ctrl: sequencer for a 32-word NTT / INTT / MULT / ADD engine.
//   Parameters: LAT_NTT, LAT_INTT, LAT_MUL -- butterfly input to write-back
//   latency for each mode (MULT and ADD share LAT_MUL).
//   Ports:
//     clk, rst              clock, asynchronous active-low reset
//     start, mode           request and mode code (see poly_pkg)
//     busy, done            operation in progress / one-cycle completion
//     rd_en, rd_addr        coefficient read, data returns next cycle
//     wr_en, wr_addr        in-place write-back of result words
//     sel, ntt_l            registered datapath opcode and layer geometry
//     tf_address            twiddle ROM address, same cycle as rd_addr
//     state_dbg             current FSM state
//     perf_cycles           busy-cycle counter, only with POLY_CTRL_PERF_CNT_EN
//   Handshake: start is a request taken only while the FSM is in IDLE (busy
//   low); a request in any other cycle, including the done cycle, is dropped.
//   An accepted request raises busy on the next cycle and holds it until the
//   cycle done pulses; no request is queued.
module poly_ctrl
  import poly_pkg::*;
#(
  parameter int LAT_NTT  = 5,
  parameter int LAT_INTT = 6,
  parameter int LAT_MUL  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        mode,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [2:0]        sel,
  output logic [1:0]        ntt_l,
  output logic [7:0]        tf_address,
  output logic [1:0]        state_dbg
`ifdef POLY_CTRL_PERF_CNT_EN
  ,
  output logic [15:0]       perf_cycles
`endif
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [7:0]        dcnt_q, dcnt_d;
  logic [2:0]        pass_q, pass_d;
  logic [1:0]        mode_q, mode_d;
  logic [2:0]        sel_q;
  logic [1:0]        ntt_l_q;
  logic [7:0]        lat_cur;
  logic              last_pass;

  always_comb begin
    case (mode_q)
      MODE_NTT:  lat_cur = 8'(LAT_NTT);
      MODE_INTT: lat_cur = 8'(LAT_INTT);
      default:   lat_cur = 8'(LAT_MUL);
    endcase
  end

  // NTT walks passes upward, INTT downward; element-wise modes are one pass.
  always_comb begin
    case (mode_q)
      MODE_NTT:  last_pass = (pass_q == 3'(N_PASSES - 1));
      MODE_INTT: last_pass = (pass_q == 3'd0);
      default:   last_pass = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      dcnt_q  <= '0;
      pass_q  <= '0;
      mode_q  <= MODE_NTT;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dcnt_q  <= dcnt_d;
      pass_q  <= pass_d;
      mode_q  <= mode_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dcnt_d  = dcnt_q;
    pass_d  = pass_q;
    mode_d  = mode_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_READ;
          cnt_d   = '0;
          mode_d  = mode;
          pass_d  = (mode == MODE_INTT) ? 3'(N_PASSES - 1) : 3'd0;
        end
      end
      ST_READ: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == ADDR_W'(N_WORDS - 1)) begin
          state_d = ST_DRAIN;
          dcnt_d  = '0;
        end
      end
      ST_DRAIN: begin
        // LAT+1 drain cycles: the final write of the pass lands in the last
        // one, so the following pass never reads a stale word.
        dcnt_d = dcnt_q + 1'b1;
        if (dcnt_q == lat_cur) begin
          cnt_d = '0;
          if (last_pass) begin
            state_d = ST_FIN;
          end else begin
            state_d = ST_READ;
            pass_d  = (mode_q == MODE_INTT) ? pass_q - 1'b1 : pass_q + 1'b1;
          end
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
        pass_d  = '0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_FIN);
  assign rd_en     = (state_q == ST_READ);
  assign rd_addr   = rd_en ? cnt_q : '0;
  assign state_dbg = state_q;

  // Twiddle index: passes 0..5 step through 2^p twiddles, each shared by a
  // run of 32>>p words; the last two passes use a distinct twiddle per word.
  always_comb begin
    tf_address = '0;
    if (rd_en && (mode_q == MODE_NTT || mode_q == MODE_INTT)) begin
      if (pass_q <= 3'd5)
        tf_address = (8'd1 << pass_q) - 8'd1 + ({3'b000, cnt_q} >> (3'd5 - pass_q));
      else
        tf_address = 8'd63 + {3'b000, cnt_q};
    end
  end

  // Opcode and geometry trail rd_en by one cycle to meet the read data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sel_q   <= SEL_IDLE;
      ntt_l_q <= '0;
    end else if (state_q == ST_READ || state_q == ST_DRAIN) begin
      sel_q   <= sel_of_mode(mode_q);
      ntt_l_q <= layer_of(mode_q, pass_q);
    end else begin
      sel_q   <= SEL_IDLE;
      ntt_l_q <= '0;
    end
  end

  assign sel   = sel_q;
  assign ntt_l = ntt_l_q;

  // One delay line per latency class; mode is fixed for a whole operation,
  // so only one line carries traffic and the outputs can be OR-ed.
  logic              v_ntt, v_intt, v_mul;
  logic [ADDR_W-1:0] a_ntt, a_intt, a_mul;

  wb_delay #(.WIDTH(ADDR_W), .DEPTH(LAT_NTT + 1)) u_wb_ntt (
    .clk      (clk),
    .rst      (rst),
    .in_valid (rd_en && (mode_q == MODE_NTT)),
    .in_data  (rd_addr),
    .out_valid(v_ntt),
    .out_data (a_ntt)
  );

  wb_delay #(.WIDTH(ADDR_W), .DEPTH(LAT_INTT + 1)) u_wb_intt (
    .clk      (clk),
    .rst      (rst),
    .in_valid (rd_en && (mode_q == MODE_INTT)),
    .in_data  (rd_addr),
    .out_valid(v_intt),
    .out_data (a_intt)
  );

  wb_delay #(.WIDTH(ADDR_W), .DEPTH(LAT_MUL + 1)) u_wb_mul (
    .clk      (clk),
    .rst      (rst),
    .in_valid (rd_en && (mode_q == MODE_MULT || mode_q == MODE_ADD)),
    .in_data  (rd_addr),
    .out_valid(v_mul),
    .out_data (a_mul)
  );

  assign wr_en   = v_ntt | v_intt | v_mul;
  assign wr_addr = a_ntt | a_intt | a_mul;

`ifdef POLY_CTRL_PERF_CNT_EN
  logic [15:0] perf_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      perf_q <= '0;
    else if (state_q == ST_IDLE && start)
      perf_q <= '0;
    else if (busy)
      perf_q <= perf_q + 16'd1;
  end

  assign perf_cycles = perf_q;
`endif

endmodule
